gray_counter: RTL
=================

Name: gray_counter

Overview:
- Parametrised, registered up/down counter that outputs both binary and reflected-Gray codes of its count.
- It is the sequential, N-bit successor to the team's fixed 4-bit combinational binary-to-Gray converter.
- It adds enable, direction, parallel load and a wrap pulse.
- It sits beside FIFO pointer and position-encoder logic, where single-bit-change count sequences are required.

Parameters:
- WIDTH, 4, count width in bits (≥2).
- RST_VAL, 0, binary count value loaded on reset (must be < 2^WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_bin  input  WIDTH  binary value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out
- wrap  output  1  one-cycle pulse on count wrap-around

Behaviour:
- Interface (already decided): one clock, clk; reset is rst, synchronous and active-high. No asynchronous paths anywhere.
- Reset values:
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL >> 1).
  - wrap = 0.
- Per-edge priority is rst > load > en. When none of them is asserted, the state holds and wrap = 0.
- Load:
  - bin_out <= load_bin and gray_out <= load_bin ^ (load_bin >> 1).
  - wrap <= 0, even if load_bin = 0 or the maximum value.
  - en and up_dn are ignored in the load cycle.
- Enabled count, up (en = 1, up_dn = 1):
  - bin_out <= bin_out + 1, modulo 2^WIDTH.
  - wrap <= 1 only when the prior bin_out = 2^WIDTH − 1.
- Enabled count, down (en = 1, up_dn = 0):
  - bin_out <= bin_out − 1, modulo 2^WIDTH.
  - wrap <= 1 only when the prior bin_out = 0.
- Latency: outputs reflect inputs sampled at edge N from edge N onward, i.e. one register stage.
  - gray_out is always the Gray code of the current bin_out, never a cycle behind.
  - gray_out is computed from the next-state binary and registered in the same edge.
- Gray property: consecutive enabled counts (no load) change exactly one bit of gray_out, including across the wrap boundary.
- Direction change: up_dn may toggle on any cycle. It takes effect at the same edge, with no dead cycle.
- Reset mid-operation: rst overrides a simultaneous load or en. wrap is forced to 0 in that cycle.
- wrap is a single-cycle pulse. A continuous count at WIDTH = 2 yields one wrap pulse every 4 enabled cycles.
- Arithmetic is unsigned, WIDTH bits. Overflow and underflow wrap silently; the only indication is the wrap pulse.

Decomposition:
- Shared package (gray_pkg):
  - function bin2gray(WIDTH): b ^ (b >> 1).
  - function gray2bin(WIDTH): prefix XOR from the MSB, for bench checking.
  - localparam default WIDTH.
- Sub-module gray_encode_n: combinational WIDTH-bit binary-to-Gray encoder, parametrised by WIDTH.
  - Instantiated once on the next-state binary.
  - Reused later by FIFO pointer logic.
- The counter core (next-state mux, wrap detect, registers) stays in gray_counter.

Test Plan:
1. Reset, then 16 enabled up counts (WIDTH=4, RST_VAL=0) → bin_out steps 0..15 then 0. gray_out follows 0000, 0001, 0011, 0010, 0110, …, 1000, then 0000. wrap = 1 only in the cycle bin_out returns to 0.
2. Down count from reset (up_dn = 0) → bin_out = 15, gray_out = 1000, wrap = 1 in the first cycle. The next count gives 14, gray_out = 1001.
3. Load load_bin = 1010 with en = 1 in the same cycle → bin_out = 1010, gray_out = 1111, wrap = 0. The next up count gives 1011 / 1110.
4. Assert rst together with load = 1, load_bin = 0101, at bin_out = 7 → bin_out = RST_VAL (0), gray_out = 0000, wrap = 0. Repeat with RST_VAL = 5: gray_out = 0111.
5. Hold en = 0 for 10 cycles at bin_out = 9 → bin_out = 9 and gray_out = 1101 are held, wrap stays 0. Then toggle up_dn every cycle with en = 1 → the count alternates 10, 9, 10, 9.
6. Random en / up_dn / load for 2000 cycles at WIDTH = 7 → the scoreboard holds in every cycle:
   - gray_out == bin2gray(bin_out).
   - Hamming distance 1 between consecutive counts without load.
   - wrap matches a reference model.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults.
// Used by the counter, its encoder and FIFO pointer logic.
package gray_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_W     = 32;

    function automatic logic [MAX_W-1:0] bin2gray(
        input logic [MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero upper bits leave the result intact.
    function automatic logic [MAX_W-1:0] gray2bin(
        input logic [MAX_W-1:0] g
    );
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_encode_n.sv
// Combinational WIDTH-bit binary to reflected-Gray encoder.
// Shared by the counter and FIFO pointer logic.
module gray_encode_n
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with binary and Gray outputs.
// Gray is encoded from next-state binary so both update together.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_BIN  = '1;
    localparam logic [WIDTH-1:0] ZERO_BIN = '0;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;

    // Next-state mux: load beats count; wrap only on a counted rollover.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + 1'b1;
                wrap_d = (bin_q == MAX_BIN);
            end else begin
                bin_d  = bin_q - 1'b1;
                wrap_d = (bin_q == ZERO_BIN);
            end
        end
    end

    gray_encode_n #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // State registers with synchronous reset taking top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule
